// File: rtl/cb_cfg_programmer_pkg.sv
// Shared types and constants for the connection-block configuration programmer.
// Holds the FSM state encoding and a constant-evaluable ceil(log2) helper.
package cb_cfg_programmer_pkg;

    localparam int CB_CFG_BITS = 48;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_LOAD,
        ST_SHIFT,
        ST_WAIT_TOK,
        ST_DONE,
        ST_ERR
    } state_t;

    // ceil(log2(value)); returns 0 for value <= 1, so callers clamp widths to >= 1.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/cb_cfg_programmer_piso.sv
// Parallel-in serial-out shifter for one host word, LSB first.
// The current bit is registered on q and holds whenever neither load nor shift_en is asserted.
module cfg_piso #(
    parameter int WORD_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              shift_en,
    input  logic [WORD_W-1:0] d,
    output logic              q
);

    logic [WORD_W-1:0] sr;

    // q presents bit 0 immediately on load; sr keeps the bits still to come.
    always_ff @(posedge clk) begin
        if (reset) begin
            sr <= '0;
            q  <= 1'b0;
        end else if (load) begin
            q  <= d[0];
            sr <= d >> 1;
        end else if (shift_en) begin
            q  <= sr[0];
            sr <= sr >> 1;
        end
    end

endmodule

// File: rtl/cb_cfg_programmer.sv
// Serialises host configuration words into a daisy chain of CB config shift registers
// and waits for the chain token to come back from the last CB.
module cb_cfg_programmer
    import cb_cfg_programmer_pkg::*;
#(
    parameter int WORD_W   = 8,
    parameter int NUM_CB   = 4,
    parameter int CB_BITS  = CB_CFG_BITS,
    parameter int DONE_TMO = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [WORD_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              bit_out,
    output logic              prgm_b,
    output logic              cb_prgm_b,
    output logic              cb_prgm_b_in,
    input  logic              cb_prgm_b_out,
    output logic              busy,
    output logic              done,
    output logic              error,
    output state_t            state
);

    localparam int TOTAL = NUM_CB * CB_BITS;
    localparam int CNT_W = (clog2(TOTAL + 1) < 1) ? 1 : clog2(TOTAL + 1);
    localparam int WB_W  = (clog2(WORD_W) < 1) ? 1 : clog2(WORD_W);
    localparam int TMO_W = (clog2(DONE_TMO) < 1) ? 1 : clog2(DONE_TMO);

    localparam logic [CNT_W-1:0] LAST_BIT      = CNT_W'(TOTAL - 1);
    localparam logic [WB_W-1:0]  LAST_WORD_BIT = WB_W'(WORD_W - 1);
    localparam logic [TMO_W-1:0] LAST_TMO      = TMO_W'(DONE_TMO - 1);

    state_t            nxt;
    logic              nxt_active;
    logic [CNT_W-1:0]  bit_cnt;
    logic [WB_W-1:0]   wb_cnt;
    logic [TMO_W-1:0]  tmo_cnt;
    logic              hs;
    logic              shift_en;

    // Host handshake: a word transfers on a rising edge where s_valid && s_ready;
    // s_ready is only ever high in LOAD, and s_valid may be held high indefinitely.
    assign hs       = s_ready && s_valid;
    assign shift_en = (state == ST_SHIFT) && (nxt == ST_SHIFT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= nxt;
        end
    end

    always_comb begin
        nxt = state;
        case (state)
            ST_IDLE:     if (start) nxt = ST_ARM;
            ST_ARM:      nxt = ST_LOAD;
            ST_LOAD: begin
                if (cb_prgm_b_out)  nxt = ST_ERR;
                else if (hs)        nxt = ST_SHIFT;
            end
            ST_SHIFT: begin
                // An early token means the physical chain is shorter than NUM_CB.
                if (cb_prgm_b_out)                nxt = ST_ERR;
                else if (bit_cnt == LAST_BIT)     nxt = ST_WAIT_TOK;
                else if (wb_cnt == LAST_WORD_BIT) nxt = ST_LOAD;
            end
            ST_WAIT_TOK: begin
                if (cb_prgm_b_out)            nxt = ST_DONE;
                else if (tmo_cnt == LAST_TMO) nxt = ST_ERR;
            end
            ST_DONE:     nxt = ST_IDLE;
            ST_ERR:      nxt = ST_IDLE;
            default:     nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        nxt_active = 1'b0;
        case (nxt)
            ST_ARM, ST_LOAD, ST_SHIFT, ST_WAIT_TOK: nxt_active = 1'b1;
            default:                                nxt_active = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt <= '0;
            wb_cnt  <= '0;
            tmo_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        bit_cnt <= '0;
                        wb_cnt  <= '0;
                        tmo_cnt <= '0;
                    end
                end
                ST_LOAD: begin
                    if (hs) wb_cnt <= '0;
                end
                ST_SHIFT: begin
                    bit_cnt <= bit_cnt + 1'b1;
                    wb_cnt  <= wb_cnt + 1'b1;
                end
                ST_WAIT_TOK: tmo_cnt <= tmo_cnt + 1'b1;
                default: ;
            endcase
        end
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            s_ready      <= 1'b0;
            prgm_b       <= 1'b1;
            cb_prgm_b    <= 1'b1;
            cb_prgm_b_in <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
        end else begin
            s_ready      <= (nxt == ST_LOAD);
            prgm_b       <= !nxt_active;
            cb_prgm_b    <= !nxt_active;
            cb_prgm_b_in <= (nxt == ST_SHIFT);
            busy         <= nxt_active;
            done         <= (nxt == ST_DONE);
            if (nxt == ST_ERR) begin
                error <= 1'b1;
            end else if (state == ST_IDLE && start) begin
                error <= 1'b0;
            end
        end
    end

    cfg_piso #(.WORD_W(WORD_W)) u_piso (
        .clk      (clk),
        .reset    (reset),
        .load     (hs),
        .shift_en (shift_en),
        .d        (s_data),
        .q        (bit_out)
    );

endmodule
